// File: rtl/music_pkg.sv
// +------------------------------------------------------------------+
// | music_pkg                                                        |
// | Shared scale codes, sequencer state type and the scale-code to   |
// | pitch divider table used by the music box song sequencer.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package music_pkg;

  localparam logic [5:0] SCALE_REST = 6'd0;
  localparam logic [5:0] SCALE_END  = 6'd63;
  localparam logic [5:0] SCALE_MAX  = 6'd36;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Divider = round(clk_hz / f) - 1. Frequencies are equal-tempered
  // (A4 = 440 Hz) rounded to centi-hertz, so the table is exact integer
  // arithmetic. Rests, unused codes and the end marker give 0.
  function automatic logic [20:0] scale_to_div(input logic [5:0] code,
                                               input longint    clk_hz);
    longint f_chz;
    case (code)
      6'd1:  f_chz = 26163;   6'd2:  f_chz = 27718;   6'd3:  f_chz = 29366;
      6'd4:  f_chz = 31113;   6'd5:  f_chz = 32963;   6'd6:  f_chz = 34923;
      6'd7:  f_chz = 36999;   6'd8:  f_chz = 39200;   6'd9:  f_chz = 41530;
      6'd10: f_chz = 44000;   6'd11: f_chz = 46616;   6'd12: f_chz = 49388;
      6'd13: f_chz = 52325;   6'd14: f_chz = 55437;   6'd15: f_chz = 58733;
      6'd16: f_chz = 62225;   6'd17: f_chz = 65926;   6'd18: f_chz = 69846;
      6'd19: f_chz = 73999;   6'd20: f_chz = 78399;   6'd21: f_chz = 83061;
      6'd22: f_chz = 88000;   6'd23: f_chz = 93233;   6'd24: f_chz = 98777;
      6'd25: f_chz = 104650;  6'd26: f_chz = 110873;  6'd27: f_chz = 117466;
      6'd28: f_chz = 124451;  6'd29: f_chz = 131851;  6'd30: f_chz = 139691;
      6'd31: f_chz = 147998;  6'd32: f_chz = 156798;  6'd33: f_chz = 166122;
      6'd34: f_chz = 176000;  6'd35: f_chz = 186466;  6'd36: f_chz = 197553;
      default: f_chz = 0;
    endcase
    if (f_chz == 0) begin
      return 21'd0;
    end
    return 21'((clk_hz * 100 + f_chz / 2) / f_chz - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/note_timer.sv
// +------------------------------------------------------------------+
// | note_timer                                                       |
// | Loadable down-counter with freeze and zero flag; times both the  |
// | sounding part of a note and the mute gap that follows it.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module note_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             freeze_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;

  // Load wins; otherwise count toward zero unless frozen, then sit at zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (!freeze_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/note_sequencer.sv
// +------------------------------------------------------------------+
// | note_sequencer                                                   |
// | Walks the song ROM, converts scale codes to pitch_div dividers,  |
// | times notes in beats with a mute gap, handles rests, pause, stop |
// | and optional looping. Optional macro TEMPO_ADJ_EN adds a 2-bit   |
// | tempo input sampled at each note start.                          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module note_sequencer
  import music_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int BEAT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 500000,
  parameter int ADDR_W      = 8,
  parameter int LOOP        = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              play_i,
  input  logic              stop_i,
`ifdef TEMPO_ADJ_EN
  input  logic [1:0]        tempo_i,
`endif
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [9:0]        rom_data_i,
  output logic [20:0]       divider_o,
  output logic [5:0]        scale_o,
  output logic              pitch_rst_o,
  output logic              mute_o,
  output logic              busy_o,
  output logic              done_o
);

  // Longest beat the counter must hold (doubled when tempo can halve speed).
`ifdef TEMPO_ADJ_EN
  localparam longint BEAT_MAX = longint'(BEAT_CYCLES) * 2;
`else
  localparam longint BEAT_MAX = longint'(BEAT_CYCLES);
`endif
  localparam int         CNT_W    = $clog2(BEAT_MAX * 15 + 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [20:0]       div_q;
  logic [5:0]        scale_q;
  logic              pitch_rst_q, mute_q, busy_q, done_q;
  logic              play_q;   // play as sampled on the previous edge
  logic              note_q;   // current entry is audible (not a rest)

  // Elaboration-time divider lookup for all 64 codes.
  logic [20:0] div_tab [64];
  for (genvar g = 0; g < 64; g++) begin : g_div_tab
    localparam logic [20:0] DIV = scale_to_div(6'(g), longint'(CLK_HZ));
    assign div_tab[g] = DIV;
  end

  logic [5:0]       w_code;
  logic [3:0]       w_beats;
  logic             w_is_end, w_is_note;
  logic [CNT_W-1:0] w_beat_len, w_note_len;
  logic             w_tmr_load, w_tmr_freeze, w_tmr_zero;
  logic [CNT_W-1:0] w_tmr_val;

  assign w_code    = rom_data_i[9:4];
  assign w_beats   = (rom_data_i[3:0] == 4'd0) ? 4'd1 : rom_data_i[3:0];
  assign w_is_end  = (w_code == SCALE_END);
  assign w_is_note = (w_code != SCALE_REST) && (w_code <= SCALE_MAX);

`ifdef TEMPO_ADJ_EN
  // Tempo is only consumed on the WAIT->PLAY edge, so a change applies from the next note.
  always_comb begin
    w_beat_len = CNT_W'(BEAT_CYCLES);
    case (tempo_i)
      2'b01:   w_beat_len = CNT_W'(BEAT_CYCLES) >> 1;
      2'b10:   w_beat_len = CNT_W'(BEAT_CYCLES) << 1;
      default: w_beat_len = CNT_W'(BEAT_CYCLES);
    endcase
  end
`else
  assign w_beat_len = CNT_W'(BEAT_CYCLES);
`endif

  assign w_note_len = w_beat_len * CNT_W'(w_beats);

  // A cycle only counts if play was high on the edge that started it, which
  // keeps counted cycles equal to audible cycles across a pause.
  assign w_tmr_freeze = !(play_q && ((state_q == ST_PLAY) || (state_q == ST_GAP)));

  // Timer reloads: cleared on stop, note length at PLAY entry, gap length at PLAY exit.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    if (stop_i) begin
      w_tmr_load = 1'b1;
    end else if ((state_q == ST_WAIT) && !w_is_end) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = w_note_len - 1'b1;
    end else if ((state_q == ST_PLAY) && play_q && w_tmr_zero) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = GAP_LOAD;
    end
  end

  note_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .freeze_i   (w_tmr_freeze),
    .zero_o     (w_tmr_zero)
  );

  // Sequencer FSM with all outputs registered; stop overrides everything but reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      div_q       <= '0;
      scale_q     <= '0;
      pitch_rst_q <= 1'b0;
      mute_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      play_q      <= 1'b0;
      note_q      <= 1'b0;
    end else begin
      play_q      <= play_i;
      pitch_rst_q <= 1'b0;
      if (stop_i) begin
        state_q <= ST_IDLE;
        addr_q  <= '0;
        div_q   <= '0;
        scale_q <= '0;
        mute_q  <= 1'b1;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        note_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (play_i) begin
              state_q <= ST_FETCH;
              busy_q  <= 1'b1;
            end
          end
          ST_FETCH: begin
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (w_is_end) begin
              if (LOOP != 0) begin
                addr_q  <= '0;
                state_q <= ST_FETCH;
              end else begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              state_q     <= ST_PLAY;
              div_q       <= w_is_note ? div_tab[w_code] : 21'd0;
              scale_q     <= w_code;
              pitch_rst_q <= 1'b1;
              note_q      <= w_is_note;
              mute_q      <= !(w_is_note && play_i);
            end
          end
          ST_PLAY: begin
            if (play_q && w_tmr_zero) begin
              state_q <= ST_GAP;
              mute_q  <= 1'b1;
            end else begin
              mute_q  <= !(note_q && play_i);
            end
          end
          ST_GAP: begin
            if (play_q && w_tmr_zero) begin
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_FETCH;
            end
          end
          ST_DONE: begin
            if (play_i && !play_q) begin
              addr_q  <= '0;
              state_q <= ST_FETCH;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mute_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign rom_addr_o  = addr_q;
  assign divider_o   = div_q;
  assign scale_o     = scale_q;
  assign pitch_rst_o = pitch_rst_q;
  assign mute_o      = mute_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
// +------------------------------------------------------------------+
// | tb_note_sequencer                                                |
// | Two sequencers (stop-at-end and looping) share stimulus and song |
// | ROM contents; a timeline model predicts every output each cycle. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_note_sequencer;

  localparam int BEAT = 10;
  localparam int GAP  = 2;
  localparam int AW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1, play = 1'b0, stop = 1'b0;
  logic [9:0]    rom [256];
  logic [AW-1:0] addr [2];
  logic [9:0]    rdat [2];
  logic [20:0]   div  [2];
  logic [5:0]    scl  [2];
  logic          prst [2], mute [2], busy [2], done [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  note_sequencer #(.CLK_HZ(50000000), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP),
                   .ADDR_W(AW), .LOOP(0)) u_dut0 (
    .clk_i(clk), .reset_i(rst), .play_i(play), .stop_i(stop),
    .rom_addr_o(addr[0]), .rom_data_i(rdat[0]), .divider_o(div[0]),
    .scale_o(scl[0]), .pitch_rst_o(prst[0]), .mute_o(mute[0]),
    .busy_o(busy[0]), .done_o(done[0]));

  note_sequencer #(.CLK_HZ(50000000), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP),
                   .ADDR_W(AW), .LOOP(1)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .play_i(play), .stop_i(stop),
    .rom_addr_o(addr[1]), .rom_data_i(rdat[1]), .divider_o(div[1]),
    .scale_o(scl[1]), .pitch_rst_o(prst[1]), .mute_o(mute[1]),
    .busy_o(busy[1]), .done_o(done[1]));

  // Synchronous song ROMs: data one cycle after the address.
  always @(posedge clk) begin
    rdat[0] <= rom[addr[0]];
    rdat[1] <= rom[addr[1]];
  end

  // Expected divider straight from the musical definition.
  function automatic int exp_div(input int code);
    real f, fc;
    if (code < 1 || code > 36) return 0;
    f  = 440.0 * (2.0 ** ((code - 10) / 12.0));
    fc = $floor(f * 100.0 + 0.5);
    return $rtoi(5.0e9 / fc + 0.5) - 1;
  endfunction

  // Timeline model: where each player is in the song.
  localparam int M_OFF = 0, M_ADDR = 1, M_DATA = 2, M_SOUND = 3, M_SPACE = 4, M_END = 5;
  int m_ph [2], m_addr [2], m_el [2], m_len [2], m_div [2], m_scl [2];
  bit m_prst [2], m_note [2], m_run [2];

  task automatic model_step(input int i);
    bit was_run;
    logic [9:0] e;
    int code, beats;
    was_run = m_run[i];
    if (rst) begin
      m_ph[i] = M_OFF; m_addr[i] = 0; m_el[i] = 0; m_len[i] = 0;
      m_div[i] = 0; m_scl[i] = 0; m_prst[i] = 0; m_note[i] = 0; m_run[i] = 0;
      return;
    end
    m_run[i]  = play;
    m_prst[i] = 0;
    if (stop) begin
      m_ph[i] = M_OFF; m_addr[i] = 0; m_div[i] = 0; m_scl[i] = 0; m_note[i] = 0;
      return;
    end
    case (m_ph[i])
      M_OFF:  if (play) m_ph[i] = M_ADDR;
      M_ADDR: m_ph[i] = M_DATA;
      M_DATA: begin
        e = rom[m_addr[i]];
        code  = int'(e[9:4]);
        beats = int'(e[3:0]);
        if (code == 63) begin
          if (i == 1) begin m_addr[i] = 0; m_ph[i] = M_ADDR; end
          else m_ph[i] = M_END;
        end else begin
          m_ph[i] = M_SOUND; m_div[i] = exp_div(code); m_scl[i] = code;
          m_prst[i] = 1; m_note[i] = (code >= 1 && code <= 36);
          m_el[i] = 0; m_len[i] = (beats == 0 ? 1 : beats) * BEAT;
        end
      end
      M_SOUND: if (was_run) begin
        m_el[i]++;
        if (m_el[i] == m_len[i]) begin m_ph[i] = M_SPACE; m_el[i] = 0; m_len[i] = GAP; end
      end
      M_SPACE: if (was_run) begin
        m_el[i]++;
        if (m_el[i] == m_len[i]) begin m_addr[i] = (m_addr[i] + 1) % 256; m_ph[i] = M_ADDR; end
      end
      M_END: if (play && !was_run) begin m_addr[i] = 0; m_ph[i] = M_ADDR; end
      default: m_ph[i] = M_OFF;
    endcase
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both players against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d.rom_addr", i), longint'(addr[i]), longint'(m_addr[i]));
        chk($sformatf("u%0d.divider", i), longint'(div[i]), longint'(m_div[i]));
        chk($sformatf("u%0d.scale", i), longint'(scl[i]), longint'(m_scl[i]));
        chk($sformatf("u%0d.pitch_rst", i), longint'(prst[i]), longint'(m_prst[i]));
        chk($sformatf("u%0d.mute", i), longint'(mute[i]),
            longint'(!(m_ph[i] == M_SOUND && m_note[i] && m_run[i])));
        chk($sformatf("u%0d.busy", i), longint'(busy[i]),
            longint'(m_ph[i] >= M_ADDR && m_ph[i] <= M_SPACE));
        chk($sformatf("u%0d.done", i), longint'(done[i]), longint'(m_ph[i] == M_END));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic restart(input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2);
    rst = 1'b1; play = 1'b0; stop = 1'b0;
    step(); step();
    for (int a = 0; a < 256; a++) rom[a] = {6'd63, 4'd0};
    rom[0] = e0; rom[1] = e1; rom[2] = e2;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int aud, aud2, np, dn;
    for (int a = 0; a < 256; a++) rom[a] = {6'd63, 4'd0};
    step();
    cmp_en = 1'b1;

    // Single A4 note, two beats.
    restart({6'd10, 4'd2}, {6'd63, 4'd0}, {6'd63, 4'd0});
    chk("reset.mute", longint'(mute[0]), 1);
    chk("reset.busy", longint'(busy[0]), 0);
    play = 1'b1; aud = 0; np = 0; dn = 0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 3) begin
        chk("t1.pitch_rst@3", longint'(prst[0]), 1);
        chk("t1.divider_A4", longint'(div[0]), 113635);
        chk("t1.mute@3", longint'(mute[0]), 0);
      end
      if (c <= 30 && !mute[0]) aud++;
      if (c == 30) begin
        chk("t1.done", longint'(done[0]), 1);
        chk("t1.busy_end", longint'(busy[0]), 0);
      end
      np += int'(prst[1]);
      dn += int'(done[1]);
    end
    chk("t1.audible", aud, 20);
    chk("loop.replays", np, 3);
    chk("loop.done", dn, 0);

    // Rest then C4.
    restart({6'd0, 4'd1}, {6'd1, 4'd1}, {6'd63, 4'd0});
    play = 1'b1; aud = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 3) begin
        chk("t2.rest_rst", longint'(prst[0]), 1);
        chk("t2.rest_div", longint'(div[0]), 0);
        chk("t2.rest_mute", longint'(mute[0]), 1);
      end
      if (c == 17) begin
        chk("t2.c4_rst", longint'(prst[0]), 1);
        chk("t2.divider_C4", longint'(div[0]), 191109);
        chk("t2.c4_mute", longint'(mute[0]), 0);
      end
      if (!mute[0]) aud++;
    end
    chk("t2.audible", aud, 10);

    // Pause for 7 cycles at note cycle 5.
    restart({6'd10, 4'd2}, {6'd63, 4'd0}, {6'd63, 4'd0});
    play = 1'b1; aud = 0; np = 0;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (!mute[0]) aud++;
      np += int'(prst[0]);
      if (c == 10) chk("t3.pause_mute", longint'(mute[0]), 1);
      if (c == 7)  play = 1'b0;
      if (c == 14) play = 1'b1;
    end
    chk("t3.audible", aud, 20);
    chk("t3.pitch_rst_count", np, 1);

    // Stop in the middle of the gap.
    restart({6'd10, 4'd2}, {6'd63, 4'd0}, {6'd63, 4'd0});
    play = 1'b1;
    for (int c = 1; c <= 23; c++) step();
    chk("t4.in_gap_mute", longint'(mute[0]), 1);
    stop = 1'b1; play = 1'b0;
    step();
    stop = 1'b0;
    chk("t4.addr", longint'(addr[0]), 0);
    chk("t4.mute", longint'(mute[0]), 1);
    chk("t4.divider", longint'(div[0]), 0);
    chk("t4.busy", longint'(busy[0]), 0);

    // Reset mid-note, then a song with a zero-beat entry.
    restart({6'd5, 4'd2}, {6'd7, 4'd0}, {6'd63, 4'd0});
    play = 1'b1;
    for (int c = 1; c <= 8; c++) step();
    rst = 1'b1;
    step();
    chk("t5.rst_div", longint'(div[0]), 0);
    chk("t5.rst_scale", longint'(scl[0]), 0);
    chk("t5.rst_prst", longint'(prst[0]), 0);
    chk("t5.rst_mute", longint'(mute[0]), 1);
    chk("t5.rst_busy", longint'(busy[0]), 0);
    rst = 1'b0; aud = 0; aud2 = 0;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (!mute[0]) begin
        if (c < 27) aud++;
        else aud2++;
      end
    end
    chk("t5.first_note", aud, 20);
    chk("t5.beats0_note", aud2, 10);

    // Randomized songs and control.
    rst = 1'b1; play = 1'b0; stop = 1'b0;
    step();
    for (int a = 0; a < 256; a++) begin
      int r;
      logic [5:0] code;
      r = int'($urandom_range(0, 99));
      if (r < 8)       code = 6'd63;
      else if (r < 20) code = 6'd0;
      else if (r < 28) code = 6'($urandom_range(37, 62));
      else             code = 6'($urandom_range(1, 36));
      rom[a] = {code, 4'($urandom_range(0, 3))};
    end
    step();
    rst = 1'b0; play = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      step();
      if ($urandom_range(0, 99) < 4) play = !play;
      stop = ($urandom_range(0, 199) == 0);
      rst  = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0; stop = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Song sequencer for the music box. Walks a synchronous song ROM of (scale, beats) entries and converts each scale code to a 21-bit divider for pitch_div.
- Times each note in beats, then inserts a short mute gap between notes. Handles rests, end-of-song, pause and optional looping.
- Sits between the button/control logic and pitch_div. It drives pitch_div's divider, scale and reset_ inputs, plus a mute gate used at the top level.

Parameters:
- CLK_HZ, 50000000, system clock frequency; used only by the package divider table.
- BEAT_CYCLES, 12500000, clock cycles per beat (default 0.25 s).
- GAP_CYCLES, 500000, mute cycles after every note or rest; must be less than BEAT_CYCLES.
- ADDR_W, 8, song ROM address width.
- LOOP, 0, 1 = restart at address 0 after the end marker; 0 = stop.

Ports:
- clk  in  1  system clock.
- reset_  in  1  synchronous, active-high reset (clock clk, reset reset_).
- play  in  1  level; 1 = run/resume, 0 = pause.
- stop  in  1  one-cycle pulse; abort and return to IDLE.
- rom_addr  out  ADDR_W  song ROM address; data returns 1 cycle later.
- rom_data  in  10  [9:4] scale code, [3:0] beats.
- divider  out  21  to pitch_div divider.
- scale  out  6  to pitch_div scale; current note code.
- pitch_rst  out  1  one-cycle pulse at each note start, tied to pitch_div reset_.
- mute  out  1  1 = silence output (gap, rest, idle, pause).
- busy  out  1  1 whenever state is not IDLE or DONE.
- done  out  1  1 in DONE (LOOP=0 end reached).

Behaviour:
- Reset values: rom_addr=0, divider=0, scale=0, pitch_rst=0, mute=1, busy=0, done=0; state IDLE; counters=0.
- Scale codes:
  - 0 = rest.
  - 1..36 = C4..B6 chromatic.
  - 63 = end marker.
  - 37..62 = treated as rest.
- Divider: divider = round(CLK_HZ/f) - 1, taken from the package table. At 50 MHz: code 10 (A4, 440 Hz) = 113635; code 1 (C4) = 191109. Rests and the end marker give divider 0.
- Beats: 0 is treated as 1. Note length = beats*BEAT_CYCLES cycles; multiplier width is computed, with no overflow for 15*BEAT_CYCLES.
- States and transitions:
  - IDLE → FETCH when play=1.
  - FETCH: rom_addr holds the current address → WAIT.
  - WAIT: register rom_data.
    - If end marker: LOOP=1 → addr=0, FETCH; LOOP=0 → DONE.
    - Otherwise → PLAY.
  - PLAY: load divider/scale, pitch_rst=1 for the entry cycle. mute=0 for notes, 1 for rests. Count beats*BEAT_CYCLES cycles → GAP.
  - GAP: mute=1 for GAP_CYCLES cycles, addr+1 → FETCH. Address wraps at 2^ADDR_W.
  - DONE: mute=1, done=1. play rising edge → addr=0, FETCH.
- Latency: play high in IDLE at cycle t → FETCH t+1, WAIT t+2, PLAY t+3 (pitch_rst, mute=0 at t+3).
- Pause: play=0 in PLAY or GAP freezes all counters and forces mute=1; divider/scale are held. play=1 resumes from the frozen count with no pitch_rst. play=0 in FETCH/WAIT completes the fetch, then freezes at PLAY entry.
- stop: highest priority except reset. Any state → IDLE next cycle, addr=0, mute=1, divider=0.
- Priority: reset_ > stop > pause.
- reset_ mid-note: immediate return to reset values; no pending pitch_rst.

Optional Feature:
- TEMPO_ADJ_EN defined:
  - Adds port tempo in 2: 00=1x, 01=2x faster (BEAT_CYCLES>>1), 10=0.5x (BEAT_CYCLES<<1), 11=1x.
  - Sampled only at PLAY entry, so a change applies from the next note.
  - Gap length is unaffected.
- Undefined: no tempo port; beat length is fixed at BEAT_CYCLES.

Decomposition:
- Package music_pkg:
  - Scale code constants: SCALE_REST=0, SCALE_END=63, SCALE_MAX=36.
  - State enum.
  - Function scale_to_div(code, CLK_HZ) returning the 21-bit divider table.
- Sub-module note_timer: loadable down-counter with a freeze input and a zero flag. It is reused for both the PLAY and GAP counts.

Test Plan (BEAT_CYCLES=10, GAP_CYCLES=2, CLK_HZ=50000000):
- ROM {(10,2),(63,0)}, LOOP=0, play=1 at t0 → pitch_rst at t0+3, divider=113635, mute=0 for 20 cycles, mute=1 for 2 cycles, then done=1, busy=0.
- ROM {(0,1),(1,1),(63,0)} → first 10 cycles of PLAY: mute=1, divider=0; then divider=191109, mute=0 for 10 cycles.
- play dropped for 7 cycles at note cycle 5 → mute=1 during the pause, no pitch_rst on resume, total audible cycles still 20.
- LOOP=1, two-note song → after the end marker, rom_addr returns to 0 and the first note replays with pitch_rst; done stays 0.
- stop pulse in mid-GAP → next cycle IDLE, rom_addr=0, mute=1, divider=0; busy=0.
- reset_ during PLAY; also beats=0 → all outputs return to reset values; a beats=0 entry plays for 10 cycles.
